// File: rtl/approx_mult_pkg.sv
// Shared constants and state encoding for the approximate shift-add multiplier.
package approx_mult_pkg;

    localparam int unsigned W      = 4;
    localparam int unsigned SEL_W  = W - 1;
    localparam int unsigned ITER   = W;
    localparam int unsigned PROD_W = 2 * W;
    localparam int unsigned CNT_W  = $clog2(ITER);

    localparam logic [SEL_W-1:0] SEL_EXACT = '0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/approx_shift_add_mult_ctrl_if.sv
// Operand-source handshake plus adder bus seen by the multiplier controller.
interface approx_shift_add_mult_ctrl_if;
    import approx_mult_pkg::*;

    logic              start;
    logic [W-1:0]      a;
    logic [W-1:0]      b;
    logic [SEL_W-1:0]  sel_cfg;
    logic [W-1:0]      add_in1;
    logic [W-1:0]      add_in2;
    logic [SEL_W-1:0]  add_sel;
    logic              add_cin;
    logic [W:0]        add_sum;
    logic              busy;
    logic              done;
    logic [PROD_W-1:0] product;

    // Controller side
    modport master (
        input  start, a, b, sel_cfg, add_sum,
        output add_in1, add_in2, add_sel, add_cin, busy, done, product
    );

    // Operand source / adder side
    modport slave (
        output start, a, b, sel_cfg, add_sum,
        input  add_in1, add_in2, add_sel, add_cin, busy, done, product
    );

endinterface

// File: rtl/approx_cp_adder.sv
// 4-bit carry-predicting adder: sel bit i replaces the carry out of stage i
// with its local generate (a&b), cutting the ripple chain at that point.
module approx_cp_adder
    import approx_mult_pkg::*;
(
    input  logic [W-1:0]     i_a,
    input  logic [W-1:0]     i_b,
    input  logic [SEL_W-1:0] i_sel,
    input  logic             i_cin,
    output logic [W:0]       o_sum_c
);

    logic [W:0]   w_c;
    logic [W-1:0] w_s;
    logic [W-1:0] w_sel_x;

    assign w_sel_x = {1'b0, i_sel};

    always_comb begin
        w_c    = '0;
        w_s    = '0;
        w_c[0] = i_cin;
        for (int i = 0; i < int'(W); i++) begin
            w_s[i] = i_a[i] ^ i_b[i] ^ w_c[i];
            if (w_sel_x[i]) begin
                w_c[i+1] = i_a[i] & i_b[i];
            end else begin
                w_c[i+1] = (i_a[i] & i_b[i]) | (w_c[i] & (i_a[i] | i_b[i]));
            end
        end
    end

    assign o_sum_c = {w_c[W], w_s};

endmodule

// File: rtl/approx_mult_datapath.sv
// Accumulator / multiplier shift register and latched operands; adder
// operands are kept registered so the adder sees clean flop outputs.
module approx_mult_datapath
    import approx_mult_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic             i_step,
    input  logic [W-1:0]     i_a,
    input  logic [W-1:0]     i_b,
    input  logic [SEL_W-1:0] i_sel,
    input  logic [W:0]       i_sum,
    output logic [W-1:0]     o_acc,
    output logic [W-1:0]     o_operand,
    output logic [SEL_W-1:0] o_sel,
    output logic [W-2:0]     o_q_hi
);

    logic [W-1:0]     r_acc;
    logic [W-1:0]     r_q;
    logic [W-1:0]     r_a;
    logic [SEL_W-1:0] r_sel;
    logic [W-1:0]     r_operand;
    logic [W-1:0]     w_q_next;

    // Sum LSB drops into the multiplier register as it shifts right
    assign w_q_next = {i_sum[0], r_q[W-1:1]};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc     <= '0;
            r_q       <= '0;
            r_a       <= '0;
            r_sel     <= '0;
            r_operand <= '0;
        end else if (i_load) begin
            r_acc     <= '0;
            r_q       <= i_b;
            r_a       <= i_a;
            r_sel     <= i_sel;
            r_operand <= i_b[0] ? i_a : '0;
        end else if (i_step) begin
            r_acc     <= i_sum[W:1];
            r_q       <= w_q_next;
            r_operand <= w_q_next[0] ? r_a : '0;
        end
    end

    assign o_acc     = r_acc;
    assign o_operand = r_operand;
    assign o_sel     = r_sel;
    assign o_q_hi    = r_q[W-1:1];

endmodule

// File: rtl/approx_shift_add_mult_ctrl.sv
// Sequential 4x4 shift-and-add multiplier driving an external approximate adder.
module approx_shift_add_mult_ctrl
    import approx_mult_pkg::*;
(
    input  logic                          clk,
    input  logic                          rst,
    approx_shift_add_mult_ctrl_if.master  bus
);

    state_e              r_state;
    state_e              w_state_next;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_busy;
    logic                r_done;
    logic [PROD_W-1:0]   r_product;
    logic                w_load;
    logic                w_step;
    logic                w_last;
    logic [W-1:0]        w_acc;
    logic [W-1:0]        w_operand;
    logic [SEL_W-1:0]    w_sel;
    logic [W-2:0]        w_q_hi;

    approx_mult_datapath u_datapath (
        .clk       (clk),
        .rst       (rst),
        .i_load    (w_load),
        .i_step    (w_step),
        .i_a       (bus.a),
        .i_b       (bus.b),
        .i_sel     (bus.sel_cfg),
        .i_sum     (bus.add_sum),
        .o_acc     (w_acc),
        .o_operand (w_operand),
        .o_sel     (w_sel),
        .o_q_hi    (w_q_hi)
    );

    // Next-state and datapath control
    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_step       = 1'b0;
        w_last       = 1'b0;
        case (r_state)
            IDLE, DONE: begin
                if (bus.start) begin
                    w_load       = 1'b1;
                    w_state_next = RUN;
                end else begin
                    w_state_next = IDLE;
                end
            end
            RUN: begin
                w_step = 1'b1;
                if (r_cnt == CNT_W'(ITER - 1)) begin
                    w_last       = 1'b1;
                    w_state_next = DONE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_product <= '0;
        end else begin
            r_state <= w_state_next;
            r_busy  <= (w_state_next == RUN);
            r_done  <= (w_state_next == DONE);
            if (w_load) begin
                r_cnt <= '0;
            end else if (w_step) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
            // Final sum plus the three surviving multiplier bits form the product
            if (w_last) begin
                r_product <= {bus.add_sum, w_q_hi};
            end
        end
    end

    assign bus.add_in1 = w_acc;
    assign bus.add_in2 = w_operand;
    assign bus.add_sel = w_sel;
    assign bus.add_cin = 1'b0;
    assign bus.busy    = r_busy;
    assign bus.done    = r_done;
    assign bus.product = r_product;

endmodule

// File: tb/tb_approx_shift_add_mult_ctrl.sv
// Directed and randomized self-checking bench for the shift-add multiplier with the real adder.
module tb_approx_shift_add_mult_ctrl;
    import approx_mult_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    approx_shift_add_mult_ctrl_if bus ();

    approx_shift_add_mult_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    approx_cp_adder u_adder (
        .i_a     (bus.add_in1),
        .i_b     (bus.add_in2),
        .i_sel   (bus.add_sel),
        .i_cin   (bus.add_cin),
        .o_sum_c (bus.add_sum)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference adder: exact sum of the low bits, with predicted carries where selected
    function automatic logic [4:0] ref_add(input logic [3:0] x, input logic [3:0] y,
                                           input logic [2:0] sel);
        logic [4:0] s;
        int         carry;
        carry = 0;
        s     = '0;
        for (int i = 0; i < 4; i++) begin
            int tot;
            tot  = int'(x[i]) + int'(y[i]) + carry;
            s[i] = tot[0];
            if (i < 3 && sel[i] == 1'b1) carry = int'(x[i] & y[i]);
            else                         carry = tot / 2;
        end
        s[4] = carry[0];
        return s;
    endfunction

    function automatic logic [7:0] ref_mult(input logic [3:0] x, input logic [3:0] y,
                                            input logic [2:0] sel);
        logic [3:0] acc;
        logic [3:0] q;
        logic [4:0] s;
        acc = '0;
        q   = y;
        for (int i = 0; i < 4; i++) begin
            s   = ref_add(acc, q[0] ? x : 4'h0, sel);
            acc = s[4:1];
            q   = {s[0], q[3:1]};
        end
        return {acc, q};
    endfunction

    // One full run from an idle negedge; scrambles inputs after the start edge
    task automatic run_mult(input logic [3:0] ia, input logic [3:0] ib, input logic [2:0] isel,
                            output logic [7:0] prod, output int nbusy, output int ndone,
                            output int lat, output logic [15:0] in1_log,
                            output logic [15:0] in2_log);
        bus.a       = ia;
        bus.b       = ib;
        bus.sel_cfg = isel;
        bus.start   = 1'b1;
        @(negedge clk);
        bus.start   = 1'b0;
        bus.a       = ~ia;
        bus.b       = ~ib;
        bus.sel_cfg = ~isel;
        prod    = '0;
        nbusy   = 0;
        ndone   = 0;
        lat     = 0;
        in1_log = '0;
        in2_log = '0;
        for (int k = 1; k <= 8; k++) begin
            if (k <= 4) begin
                in1_log = {in1_log[11:0], bus.add_in1};
                in2_log = {in2_log[11:0], bus.add_in2};
            end
            if (bus.busy) nbusy++;
            if (bus.done) begin
                ndone++;
                prod = bus.product;
                lat  = k;
            end
            @(negedge clk);
        end
    endtask

    // Waits up to max_cyc negedges for done; leaves time at the done cycle
    task automatic wait_done(input int max_cyc, output logic [7:0] prod, output int lat);
        bit found;
        found = 1'b0;
        lat   = 0;
        prod  = '0;
        for (int k = 1; k <= max_cyc && !found; k++) begin
            if (bus.done) begin
                found = 1'b1;
                lat   = k;
                prod  = bus.product;
            end else begin
                @(negedge clk);
            end
        end
    endtask

    initial begin
        logic [7:0]  prod;
        logic [15:0] l1;
        logic [15:0] l2;
        int          nb;
        int          nd;
        int          lat;

        bus.start   = 1'b0;
        bus.a       = '0;
        bus.b       = '0;
        bus.sel_cfg = '0;
        rst         = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_busy",    32'(bus.busy),    32'h0);
        check("rst_done",    32'(bus.done),    32'h0);
        check("rst_product", 32'(bus.product), 32'h00);
        check("rst_in1",     32'(bus.add_in1), 32'h0);
        check("rst_in2",     32'(bus.add_in2), 32'h0);
        check("rst_sel",     32'(bus.add_sel), 32'h0);
        check("rst_cin",     32'(bus.add_cin), 32'h0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_busy", 32'(bus.busy), 32'h0);

        // Exact 15*15
        run_mult(4'hF, 4'hF, SEL_EXACT, prod, nb, nd, lat, l1, l2);
        check("ff_product", 32'(prod), 32'hE1);
        check("ff_busy_cyc", 32'(nb), 32'd4);
        check("ff_done_cnt", 32'(nd), 32'd1);
        check("ff_latency", 32'(lat), 32'd5);
        check("ff_in1_seq", 32'(l1), 32'h07BD);
        check("ff_in2_seq", 32'(l2), 32'hFFFF);

        // Exact 10*3: operand gated off on q[0]=0 cycles
        run_mult(4'hA, 4'h3, SEL_EXACT, prod, nb, nd, lat, l1, l2);
        check("a3_product", 32'(prod), 32'h1E);
        check("a3_in1_seq", 32'(l1), 32'h0573);
        check("a3_in2_seq", 32'(l2), 32'hAA00);

        run_mult(4'h0, 4'h9, SEL_EXACT, prod, nb, nd, lat, l1, l2);
        check("zero_product", 32'(prod), 32'h00);
        check("zero_in2_seq", 32'(l2), 32'h0000);

        // Approximate 15*15 with all carries predicted
        run_mult(4'hF, 4'hF, 3'b111, prod, nb, nd, lat, l1, l2);
        check("approx_ff", 32'(prod), 32'hA1);
        check("sel_latched", 32'(bus.add_sel), 32'h7);
        check("cin_zero", 32'(bus.add_cin), 32'h0);

        // start during RUN is ignored
        bus.a = 4'h2; bus.b = 4'h3; bus.sel_cfg = SEL_EXACT; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        nb = 0; nd = 0; prod = '0;
        for (int k = 1; k <= 10; k++) begin
            if (bus.busy) nb++;
            if (bus.done) begin
                nd++;
                prod = bus.product;
            end
            if (k == 2) begin
                bus.start = 1'b1; bus.a = 4'h5; bus.b = 4'h5;
            end else begin
                bus.start = 1'b0;
            end
            @(negedge clk);
        end
        check("midstart_product", 32'(prod), 32'h06);
        check("midstart_done_cnt", 32'(nd), 32'd1);
        check("midstart_busy_cyc", 32'(nb), 32'd4);

        // Reset on the second RUN cycle aborts the run
        bus.a = 4'hF; bus.b = 4'hF; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("abort_busy", 32'(bus.busy), 32'h0);
        check("abort_done", 32'(bus.done), 32'h0);
        check("abort_product", 32'(bus.product), 32'h00);
        check("abort_in1", 32'(bus.add_in1), 32'h0);
        rst = 1'b0;
        nb = 0; nd = 0;
        for (int k = 1; k <= 8; k++) begin
            if (bus.busy) nb++;
            if (bus.done) nd++;
            @(negedge clk);
        end
        check("abort_no_done", 32'(nd), 32'd0);
        check("abort_no_busy", 32'(nb), 32'd0);

        // Back-to-back: start held high through DONE
        bus.a = 4'h3; bus.b = 4'h5; bus.sel_cfg = SEL_EXACT; bus.start = 1'b1;
        @(negedge clk);
        wait_done(10, prod, lat);
        check("b2b_first_product", 32'(prod), 32'h0F);
        check("b2b_first_latency", 32'(lat), 32'd5);
        check("b2b_done_busy", 32'(bus.busy), 32'h0);
        bus.a = 4'h7; bus.b = 4'h6;
        @(negedge clk);
        bus.start = 1'b0;
        check("b2b_restart_busy", 32'(bus.busy), 32'h1);
        wait_done(10, prod, lat);
        check("b2b_second_product", 32'(prod), 32'h2A);
        check("b2b_second_latency", 32'(lat), 32'd5);
        repeat (2) @(negedge clk);

        // Exact mode across all operand pairs
        for (int i = 0; i < 16; i++) begin
            for (int j = 0; j < 16; j++) begin
                logic [7:0] exp_p;
                exp_p = 8'(i) * 8'(j);
                run_mult(4'(i), 4'(j), SEL_EXACT, prod, nb, nd, lat, l1, l2);
                check("exact_all", 32'(prod), 32'(exp_p));
            end
        end

        // Approximate mode against the reference composition
        for (int n = 0; n < 200; n++) begin
            logic [3:0] ra;
            logic [3:0] rb;
            ra = 4'($urandom_range(0, 15));
            rb = 4'($urandom_range(0, 15));
            run_mult(ra, rb, 3'b111, prod, nb, nd, lat, l1, l2);
            check("approx_rand", 32'(prod), 32'(ref_mult(ra, rb, 3'b111)));
        end
        for (int n = 0; n < 20; n++) begin
            logic [3:0] ra;
            logic [3:0] rb;
            logic [2:0] rs;
            ra = 4'($urandom_range(0, 15));
            rb = 4'($urandom_range(0, 15));
            rs = 3'($urandom_range(0, 7));
            run_mult(ra, rb, rs, prod, nb, nd, lat, l1, l2);
            check("mixed_sel_rand", 32'(prod), 32'(ref_mult(ra, rb, rs)));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
